bus_host_arbiter: RTL
=====================

BUS_HOST_ARBITER -- requirements
Module: bus_host_arbiter

Interface
REQ-001 Parameter NrHosts, default 2, number of requesting hosts (2..8).
REQ-002 Parameter DataWidth, default 32, data width in bits.
REQ-003 Parameter AddressWidth, default 32, address width in bits.
REQ-004 Parameter MaxOutstanding, default 2, maximum accepted-but-unanswered transactions (1..8).
REQ-005 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low.
REQ-006 Port clk_i, input, 1, clock.
REQ-007 Port rst_ni, input, 1, asynchronous active-low reset.
REQ-008 Ports host_req_i / host_we_i, input, 1 per host, request and write-enable per host.
REQ-009 Ports host_addr_i / host_wdata_i / host_be_i, input, AddressWidth / DataWidth / DataWidth/8 per host, request payload.
REQ-010 Ports host_gnt_o / host_rvalid_o / host_err_o, output, 1 per host, grant, response valid and response error.
REQ-011 Port host_rdata_o, output, DataWidth per host, read data.
REQ-012 Ports out_req_o / out_we_o, output, 1, request and write-enable to the shared bus host slot.
REQ-013 Ports out_addr_o / out_wdata_o / out_be_o, output, AddressWidth / DataWidth / DataWidth/8, request payload to the bus.
REQ-014 Ports out_gnt_i / out_rvalid_i / out_err_i, input, 1, bus grant, response valid and response error.
REQ-015 Port out_rdata_i, input, DataWidth, bus read data.

Function
REQ-016 out_req_o SHALL be asserted when any host_req_i is high and the outstanding count is below MaxOutstanding.
REQ-017 The payload of the selected host SHALL be muxed to out_*; host_gnt_o[i] SHALL equal out_gnt_i AND out_req_o AND (selected==i), combinationally with zero latency.
REQ-018 Lock: if out_req_o is high and out_gnt_i is low, the selection SHALL be registered and held until the cycle of grant; a new arbitration SHALL occur only after that grant.
REQ-019 Each accepted request (out_req_o and out_gnt_i) SHALL push the winning host index into an in-order ID FIFO of depth MaxOutstanding.
REQ-020 On out_rvalid_i the FIFO head SHALL be popped; host_rvalid_o[head] SHALL be driven high in the same cycle, with out_rdata_i and out_err_i routed to that host only.
REQ-021 Non-addressed hosts SHALL see rvalid=0, err=0 and rdata=0.
REQ-022 A simultaneous push and pop SHALL leave the count unchanged; when count==MaxOutstanding, out_req_o SHALL be low even if that cycle pops.
REQ-023 out_rvalid_i with an empty FIFO SHALL be dropped, with no host response; a simulation assertion SHALL flag it.
REQ-024 Arbitration order: see REQ-029 and REQ-030; the priority pointer SHALL update only on an accepted request.

Reset
REQ-025 On reset assertion, all of the following SHALL apply immediately: FIFO emptied, count=0, lock cleared, priority pointer=0.
REQ-026 The following outputs SHALL be 0 during reset: out_req_o, all host_gnt_o, all host_rvalid_o and all host_err_o.
REQ-027 Reset mid-transaction SHALL discard in-flight IDs; responses arriving after reset release SHALL be handled per REQ-023.

Configuration
REQ-028 The macro BUS_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-029 With BUS_ARB_ROUND_ROBIN_EN defined: round-robin; the search SHALL start at (last granted index + 1) mod NrHosts.
REQ-030 Without BUS_ARB_ROUND_ROBIN_EN: fixed priority, lowest index first; the pointer register SHALL be absent.

Structure
REQ-031 Shared package bus_arb_pkg SHALL hold the host-index typedef (width $clog2(NrHosts), minimum 1) and the MaxOutstanding limit constant.
REQ-032 The ID FIFO SHALL be a sub-module bus_arb_id_fifo (push, pop, head, count, full, empty).
REQ-033 Target size SHALL be 150-300 RTL lines; the block SHALL be instantiable between the core data port plus one extra host and the existing bus host slot 0.

Verification
REQ-034 Single host: host0 reads 0x100010, gnt held 1, rvalid 1 cycle later with rdata 0xDEADBEEF -> host0 sees gnt in cycle 0, rvalid and 0xDEADBEEF in cycle 1, host1 sees nothing.
REQ-035 Contention with round-robin: both hosts request continuously for 4 grants -> grant order 0,1,0,1; fixed-priority build -> 0,0,0,0.
REQ-036 Back-pressure: host1 is selected and out_gnt_i is low for 3 cycles while host0 raises req -> out_addr_o stays host1's address until grant, then host0 is served.
REQ-037 Outstanding limit with MaxOutstanding=2: grants in cycles 0 and 1 with no rvalid -> out_req_o is 0 in cycle 2; rvalid in cycle 3 goes to host0, and out_req_o reasserts in cycle 4.
REQ-038 Error routing: host1 write with out_err_i=1 on its response -> host_err_o[1]=1 and host_err_o[0]=0.
REQ-039 Reset mid-flight: rst_ni is pulsed with 2 outstanding, then out_rvalid_i arrives -> no host_rvalid_o and the assertion fires.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and limits for the bus host arbiter.
// Holds host-index sizing helpers and the outstanding limit.
package bus_arb_pkg;

  localparam int unsigned MaxNrHosts          = 8;
  localparam int unsigned MaxOutstandingLimit = 8;
  localparam int unsigned NrHostsDefault      = 2;

  // Index width for n entries, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must reach n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned HostIdxWidth = idx_width(NrHostsDefault);

  typedef logic [HostIdxWidth-1:0] host_idx_t;

endpackage

// File: rtl/bus_arb_id_fifo.sv
// In-order FIFO of host indices for accepted bus requests.
// Push on full and pop on empty are ignored.
module bus_arb_id_fifo
  import bus_arb_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1,
  localparam int unsigned CntW = cnt_width(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = idx_width(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers, cleared by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/bus_host_arbiter.sv
// Multi-host arbiter onto one bus host slot with in-order responses.
// BUS_ARB_ROUND_ROBIN_EN selects round-robin, else fixed priority.
module bus_host_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned NrHosts        = 2,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NrHosts-1:0]                     host_req_i,
  input  logic [NrHosts-1:0]                     host_we_i,
  input  logic [NrHosts-1:0][AddressWidth-1:0]   host_addr_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]      host_wdata_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]    host_be_i,
  output logic [NrHosts-1:0]                     host_gnt_o,
  output logic [NrHosts-1:0]                     host_rvalid_o,
  output logic [NrHosts-1:0]                     host_err_o,
  output logic [NrHosts-1:0][DataWidth-1:0]      host_rdata_o,
  output logic                                   out_req_o,
  output logic                                   out_we_o,
  output logic [AddressWidth-1:0]                out_addr_o,
  output logic [DataWidth-1:0]                   out_wdata_o,
  output logic [DataWidth/8-1:0]                 out_be_o,
  input  logic                                   out_gnt_i,
  input  logic                                   out_rvalid_i,
  input  logic                                   out_err_i,
  input  logic [DataWidth-1:0]                   out_rdata_i
);

  localparam int unsigned IdxW = idx_width(NrHosts);
  localparam int unsigned CntW = cnt_width(MaxOutstanding);

  typedef logic [IdxW-1:0] idx_t;

  idx_t            sel, arb_idx, head;
  idx_t            lock_idx_q, lock_idx_d;
  logic            lock_q, lock_d;
  logic            any_req, push, pop, full, empty;
  logic            rsp_drop;
  logic [CntW-1:0] count;

  assign any_req   = |host_req_i;
  assign sel       = lock_q ? lock_idx_q : arb_idx;
  assign out_req_o = rst_ni && !full && (lock_q || any_req);
  assign push      = out_req_o && out_gnt_i;
  assign pop       = out_rvalid_i && !empty;
  assign rsp_drop  = out_rvalid_i && empty;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  idx_t ptr_q, ptr_d;

  // Round-robin pick starting at the slot after the last winner.
  always_comb begin
    logic found;
    int   j;
    found   = 1'b0;
    j       = 0;
    arb_idx = '0;
    for (int k = 0; k < int'(NrHosts); k++) begin
      j = (int'(ptr_q) + k) % int'(NrHosts);
      if (!found && host_req_i[j]) begin
        found   = 1'b1;
        arb_idx = idx_t'(j);
      end
    end
  end

  // Pointer moves past the winner only on an accepted request.
  always_comb begin
    ptr_d = ptr_q;
    if (push) begin
      ptr_d = (int'(sel) == int'(NrHosts) - 1) ? '0 : sel + 1'b1;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
`else
  // Fixed priority pick, lowest index wins.
  always_comb begin
    logic found;
    found   = 1'b0;
    arb_idx = '0;
    for (int k = 0; k < int'(NrHosts); k++) begin
      if (!found && host_req_i[k]) begin
        found   = 1'b1;
        arb_idx = idx_t'(k);
      end
    end
  end
`endif

  // Hold the selection while the bus stalls the request.
  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (out_req_o && !out_gnt_i) begin
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end else if (push) begin
      lock_d = 1'b0;
    end
  end

  // Lock registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // Request payload mux and per-host grant.
  always_comb begin
    out_we_o    = host_we_i[sel];
    out_addr_o  = host_addr_i[sel];
    out_wdata_o = host_wdata_i[sel];
    out_be_o    = host_be_i[sel];
    host_gnt_o  = '0;
    if (push) host_gnt_o[sel] = 1'b1;
  end

  // Route the response to the host at the FIFO head only.
  always_comb begin
    host_rvalid_o = '0;
    host_err_o    = '0;
    host_rdata_o  = '0;
    if (pop) begin
      host_rvalid_o[head] = 1'b1;
      host_err_o[head]    = out_err_i;
      host_rdata_o[head]  = out_rdata_i;
    end
  end

  bus_arb_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (sel),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  a_no_orphan_rsp: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !rsp_drop
  ) else $warning("bus_host_arbiter: response with empty id fifo dropped");

  a_count_bound: assert property (
    @(posedge clk_i) disable iff (!rst_ni) count <= CntW'(MaxOutstanding)
  );

endmodule
